// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue
//   Instruction-fetch front end. A PC register drives the instruction memory
//   port. Returned instructions go into a DEPTH-entry circular prefetch queue
//   that the ID stage drains. A redirect (taken branch, jump or trap) flushes
//   the queue. If a fetch is still outstanding when the redirect arrives, the
//   FSM enters DRAIN: it waits for that stale response, throws it away, and
//   then resumes fetching at the saved target.
//
// Handshakes:
//   imem_read/imem_resp : a request is raised with imem_read and
//     imem_address. It completes in the cycle where imem_resp=1, which may be
//     the same cycle the request is raised. Until then imem_read and
//     imem_address stay stable.
//   id_valid/deq : the head entry is consumed in a cycle with id_valid=1,
//     deq=1, global_stall=0 and redirect=0. In any other cycle deq has no
//     effect.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   imem_read, imem_address fetch request and address (address = PC register)
//   imem_resp, imem_rdata   memory response strobe and data
//   redirect, redirect_pc   control-flow change and its target
//   global_stall            pipeline freeze: blocks new issue and dequeue
//   deq                     ID consumes the head entry
//   id_valid                queue is non-empty
//   instruction_out         head instruction (0 when empty)
//   pc_inc_out              head PC+2 (0 when empty)
//   reset_sig               downstream flush pulse (mirrors redirect)
//   q_count                 queue occupancy
//   dbg_state_o             fetch FSM state (0 = RUN, 1 = DRAIN)
module if_prefetch_queue #(
  parameter int unsigned      WIDTH    = 16,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  output logic                         imem_read,
  output logic [WIDTH-1:0]             imem_address,
  input  logic                         imem_resp,
  input  logic [WIDTH-1:0]             imem_rdata,
  input  logic                         redirect,
  input  logic [WIDTH-1:0]             redirect_pc,
  input  logic                         global_stall,
  input  logic                         deq,
  output logic                         id_valid,
  output logic [WIDTH-1:0]             instruction_out,
  output logic [WIDTH-1:0]             pc_inc_out,
  output logic                         reset_sig,
  output logic [$clog2(DEPTH+1)-1:0]   q_count,
  output logic                         dbg_state_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] tgt_q;
  logic             busy_q;

  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;

  logic [WIDTH-1:0] instr_mem [DEPTH];
  logic [WIDTH-1:0] pcinc_mem [DEPTH];

  logic [WIDTH-1:0] pc_plus2;
  logic             enq;
  logic             do_deq;

  // Wraps modulo 2^WIDTH, so 0xFFFE + 2 becomes 0x0000.
  assign pc_plus2 = pc_q + WIDTH'(2);

  // New issue is based on the registered count. A response can therefore
  // never land in a full queue: at most one request is outstanding, and it
  // was only issued while count < DEPTH.
  assign imem_read = busy_q
                   | (state_q == ST_DRAIN)
                   | ((state_q == ST_RUN) && (count_q < CW'(DEPTH)) && !global_stall);
  assign imem_address = pc_q;

  // Returned data is captured even during global_stall. A redirect in the
  // same cycle makes the data stale.
  assign enq    = (state_q == ST_RUN) && imem_resp && !redirect;
  assign do_deq = deq && id_valid && !global_stall && !redirect;

  assign reset_sig   = redirect;
  assign dbg_state_o = (state_q == ST_DRAIN);

  // Fetch FSM: PC, redirect target, outstanding-request flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      tgt_q   <= RESET_PC;
      busy_q  <= 1'b0;
    end else begin
      // Remembers a request that has not completed yet, so that address and
      // read strobe are held regardless of stall or queue fullness.
      busy_q <= imem_read && !imem_resp;
      case (state_q)
        ST_RUN: begin
          if (redirect) begin
            if (imem_read && !imem_resp) begin
              // A fetch to the old stream is in flight: park the target.
              tgt_q   <= redirect_pc;
              state_q <= ST_DRAIN;
            end else begin
              pc_q <= redirect_pc;
            end
          end else if (imem_resp) begin
            pc_q <= pc_plus2;
          end
        end
        ST_DRAIN: begin
          if (imem_resp) begin
            // The stale response is dropped. A redirect arriving in the same
            // cycle is newer than the parked target.
            pc_q    <= redirect ? redirect_pc : tgt_q;
            state_q <= ST_RUN;
          end else if (redirect) begin
            tgt_q <= redirect_pc;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  // Queue bookkeeping. Pointers wrap naturally because DEPTH is a power of 2.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (redirect) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (enq)    wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_deq) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({enq, do_deq})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage needs no reset: it is only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (enq) begin
      instr_mem[wr_ptr_q] <= imem_rdata;
      pcinc_mem[wr_ptr_q] <= pc_plus2;
    end
  end

  assign id_valid        = (count_q != '0);
  assign instruction_out = id_valid ? instr_mem[rd_ptr_q] : '0;
  assign pc_inc_out      = id_valid ? pcinc_mem[rd_ptr_q] : '0;
  assign q_count         = count_q;

endmodule
